// File: rtl/audio_i2s_receiver_pkg.sv
// Shared audio definitions: channel width, word-select encoding and the
// stereo pair type used by both the receiver and the speaker-side serializer.
package audio_i2s_receiver_pkg;

    localparam int DATA_W = 16;

    localparam logic WS_LEFT  = 1'b1;
    localparam logic WS_RIGHT = 1'b0;

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } stereo_sample_t;

    // Word-assembly state: UNALIGNED drops bits until a ws change is seen,
    // OVERRUN drops bits after a too-long word until the next ws change.
    typedef enum logic [1:0] {
        ST_UNALIGNED = 2'd0,
        ST_RECEIVING = 2'd1,
        ST_OVERRUN   = 2'd2
    } rx_state_e;

endpackage

// File: rtl/audio_i2s_receiver_in_sync.sv
// Oversampling front end for the serial audio pins: every pin goes through the
// same number of synchronizer flops so bck, ws and data keep their relative
// timing, and a rising-edge detector on the synchronized bck marks capture points.
module audio_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bck_i,
    input  logic ws_i,
    input  logic data_i,
    output logic bck_rise_o,
    output logic ws_s_o,
    output logic data_s_o
);

    logic [2:0] raw;
    logic [2:0] synced;
    logic       bck_prev_q;

    assign raw = {bck_i, ws_i, data_i};

    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [SYNC_STAGES-1:0] chain_q;

        // Shift the raw pin level through the synchronizer chain.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain_q <= '0;
            end else begin
                chain_q <= {chain_q[SYNC_STAGES-2:0], raw[gi]};
            end
        end

        assign synced[gi] = chain_q[SYNC_STAGES-1];
    end

    // Remember the previous synchronized bck level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_prev_q <= 1'b0;
        end else begin
            bck_prev_q <= synced[2];
        end
    end

    assign bck_rise_o = synced[2] & ~bck_prev_q;
    assign ws_s_o     = synced[1];
    assign data_s_o   = synced[0];

endmodule

// File: rtl/audio_i2s_receiver.sv
// Serial audio receiver (slave): assembles MSB-first left/right words from an
// external ADC/codec and presents each clean left+right pair with a one-clk
// valid strobe. Malformed (short or long) words raise a one-clk frame_err.
module audio_i2s_receiver #(
    parameter int DATA_W      = audio_i2s_receiver_pkg::DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              audio_bck,
    input  logic              audio_ws,
    input  logic              audio_data,
    output logic [DATA_W-1:0] sample_left,
    output logic [DATA_W-1:0] sample_right,
    output logic              sample_valid,
    output logic              frame_err
);

    import audio_i2s_receiver_pkg::*;

    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_OVR  = '1;

    logic bck_rise;
    logic ws_s;
    logic data_s;

    audio_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .bck_i      (audio_bck),
        .ws_i       (audio_ws),
        .data_i     (audio_data),
        .bck_rise_o (bck_rise),
        .ws_s_o     (ws_s),
        .data_s_o   (data_s)
    );

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              prev_ws_q, prev_ws_d;
    logic [DATA_W-1:0] left_pend_q, left_pend_d;
    logic              left_ok_q, left_ok_d;
    logic              commit_q, commit_d;
    logic              err_d;
    logic              word_done;

    logic [DATA_W-1:0] sample_left_q;
    logic [DATA_W-1:0] sample_right_q;
    logic              sample_valid_q;
    logic              frame_err_q;

    // Word assembly: act only on synchronized bck rising edges.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        prev_ws_d   = prev_ws_q;
        left_pend_d = left_pend_q;
        left_ok_d   = left_ok_q;
        commit_d    = 1'b0;
        err_d       = 1'b0;
        word_done   = 1'b0;

        if (bck_rise) begin
            if (ws_s != prev_ws_q) begin
                // A ws change always starts a new word; an unfinished previous
                // word is flagged in the same cycle.
                if (state_q == ST_RECEIVING && bit_cnt_q < CNT_FULL) begin
                    err_d = 1'b1;
                end
                shift_d   = {{(DATA_W-1){1'b0}}, data_s};
                bit_cnt_d = CNT_ONE;
                prev_ws_d = ws_s;
                state_d   = ST_RECEIVING;
            end else begin
                case (state_q)
                    ST_RECEIVING: begin
                        if (bit_cnt_q < CNT_FULL) begin
                            shift_d   = {shift_q[DATA_W-2:0], data_s};
                            bit_cnt_d = bit_cnt_q + CNT_ONE;
                            word_done = (bit_cnt_q == CNT_LAST);
                        end else begin
                            // Extra bit beyond a full word: flag once, then idle
                            // until ws changes.
                            err_d     = 1'b1;
                            bit_cnt_d = CNT_OVR;
                            state_d   = ST_OVERRUN;
                        end
                    end
                    default: begin
                        // UNALIGNED / OVERRUN: drop bits silently.
                    end
                endcase
            end

            if (word_done) begin
                if (prev_ws_q == WS_LEFT) begin
                    left_pend_d = shift_d;
                    left_ok_d   = 1'b1;
                end else begin
                    // A right word only publishes if a clean left preceded it.
                    commit_d  = left_ok_q;
                    left_ok_d = 1'b0;
                end
            end

            if (err_d) begin
                left_ok_d = 1'b0;
            end
        end
    end

    // Word-assembly state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_UNALIGNED;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            prev_ws_q   <= 1'b0;
            left_pend_q <= '0;
            left_ok_q   <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            prev_ws_q   <= prev_ws_d;
            left_pend_q <= left_pend_d;
            left_ok_q   <= left_ok_d;
            commit_q    <= commit_d;
        end
    end

    // Output pair: both channels update together, one clk after the commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_left_q  <= '0;
            sample_right_q <= '0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            if (commit_q) begin
                sample_left_q  <= left_pend_q;
                sample_right_q <= shift_q;
            end
            sample_valid_q <= commit_q;
            frame_err_q    <= err_d;
        end
    end

    assign sample_left  = sample_left_q;
    assign sample_right = sample_right_q;
    assign sample_valid = sample_valid_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_audio_i2s_receiver.sv
// Directed bench for the serial audio receiver: a bit-level serializer model
// drives bck = clk/8, a monitor tracks valid/err pulses, and table-driven
// frames plus hand-written corner sequences are checked against literals.
module tb_audio_i2s_receiver;

    localparam int W  = 16;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bck = 1'b0;
    logic         ws = 1'b0;
    logic         din = 1'b0;
    logic [W-1:0] sample_left;
    logic [W-1:0] sample_right;
    logic         sample_valid;
    logic         frame_err;

    audio_i2s_receiver #(
        .DATA_W      (W),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .audio_bck    (bck),
        .audio_ws     (ws),
        .audio_data   (din),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .frame_err    (frame_err)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int err_run = 0;
    int err_max = 0;
    int last_rise_cyc = 0;
    int valid_cyc_q[$];
    logic [W-1:0] last_l = '0;
    logic [W-1:0] last_r = '0;
    logic [W-1:0] prev_l = '0;
    logic [W-1:0] prev_r = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sample just after each active edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (sample_valid) begin
                valid_cnt++;
                last_l = sample_left;
                last_r = sample_right;
                valid_cyc_q.push_back(cyc);
            end else if (sample_left !== prev_l || sample_right !== prev_r) begin
                checks++;
                errors++;
                $display("FAIL out_hold: outputs changed to %h/%h without valid (were %h/%h)",
                         sample_left, sample_right, prev_l, prev_r);
            end
            if (frame_err) begin
                err_run++;
                if (err_run == 1) err_cnt++;
            end else if (err_run > 0) begin
                if (err_run > err_max) err_max = err_run;
                err_run = 0;
            end
        end
        prev_l = sample_left;
        prev_r = sample_right;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // One serial bit: caller is at a clk negedge; bck low 4 clk, high 4 clk.
    task automatic send_bit(input logic w, input logic d);
        bck = 1'b0;
        ws  = w;
        din = d;
        repeat (4) @(negedge clk);
        bck = 1'b1;
        last_rise_cyc = cyc;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input logic w, input logic [W-1:0] word, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w, word[i]);
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        send_bits(1'b1, l, W-1, 0);
        send_bits(1'b0, r, W-1, 0);
    endtask

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic [W-1:0] exp_l;
        logic [W-1:0] exp_r;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int v0;
        int e0;

        vecs[0] = '{16'h1234, 16'hABCD, 16'h1234, 16'hABCD};
        vecs[1] = '{16'h1234, 16'hABCD, 16'h1234, 16'hABCD};
        vecs[2] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
        vecs[3] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
        vecs[4] = '{16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_left", 32'(sample_left), 32'h0);
        check("reset_right", 32'(sample_right), 32'h0);
        check("reset_valid", 32'(sample_valid), 32'h0);
        check("reset_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back clean frames
        v0 = valid_cnt;
        e0 = err_cnt;
        valid_cyc_q.delete();
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].l, vecs[i].r);
            check("vec_valid_cnt", 32'(valid_cnt), 32'(v0 + i + 1));
            check("vec_left", 32'(last_l), 32'(vecs[i].exp_l));
            check("vec_right", 32'(last_r), 32'(vecs[i].exp_r));
            check("vec_no_err", 32'(err_cnt), 32'(e0));
            if (valid_cyc_q.size() > 0)
                check("vec_latency", 32'(valid_cyc_q[valid_cyc_q.size()-1] - last_rise_cyc), 32'(SS + 2));
        end
        check("vec_pulses", 32'(valid_cyc_q.size()), 32'd5);
        if (valid_cyc_q.size() == 5) begin
            for (int k = 1; k < 5; k++)
                check("vec_period", 32'(valid_cyc_q[k] - valid_cyc_q[k-1]), 32'd256);
        end

        // Short left word (12 bits), then a right word that must be discarded
        v0 = valid_cnt;
        e0 = err_cnt;
        err_max = 0;
        send_bits(1'b1, 16'hDEAD, 15, 4);
        send_bits(1'b0, 16'h1111, 15, 0);
        check("short_err_cnt", 32'(err_cnt), 32'(e0 + 1));
        check("short_err_width", 32'(err_max), 32'd1);
        check("short_no_valid", 32'(valid_cnt), 32'(v0));
        send_frame(16'h2468, 16'h9BDF);
        check("short_recover_cnt", 32'(valid_cnt), 32'(v0 + 1));
        check("short_recover_left", 32'(last_l), 32'h2468);
        check("short_recover_right", 32'(last_r), 32'h9BDF);
        check("short_recover_err", 32'(err_cnt), 32'(e0 + 1));

        // Long left word (17 bits)
        v0 = valid_cnt;
        e0 = err_cnt;
        err_max = 0;
        send_bits(1'b1, 16'hCAFE, 15, 0);
        send_bit(1'b1, 1'b1);
        send_bits(1'b0, 16'h4321, 15, 0);
        check("long_err_cnt", 32'(err_cnt), 32'(e0 + 1));
        check("long_err_width", 32'(err_max), 32'd1);
        check("long_no_valid", 32'(valid_cnt), 32'(v0));
        send_frame(16'h1357, 16'hFDB9);
        check("long_recover_cnt", 32'(valid_cnt), 32'(v0 + 1));
        check("long_recover_left", 32'(last_l), 32'h1357);
        check("long_recover_right", 32'(last_r), 32'hFDB9);

        // Start mid-right-word after a reset (first edge carries bit 6)
        bck = 1'b0;
        ws  = 1'b0;
        din = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(1'b0, 16'h5555, 6, 0);
        check("midright_no_valid", 32'(valid_cnt), 32'(v0));
        check("midright_no_err", 32'(err_cnt), 32'(e0));
        send_frame(16'h8001, 16'h7FFE);
        check("midright_cnt", 32'(valid_cnt), 32'(v0 + 1));
        check("midright_left", 32'(last_l), 32'h8001);
        check("midright_right", 32'(last_r), 32'h7FFE);
        check("midright_err", 32'(err_cnt), 32'(e0));
        if (valid_cyc_q.size() > 0)
            check("midright_latency", 32'(valid_cyc_q[valid_cyc_q.size()-1] - last_rise_cyc), 32'(SS + 2));

        // Reset for 3 clk in the middle of a left word
        send_bits(1'b1, 16'hFFFF, 15, 8);
        rst_n = 1'b0;
        #1;
        check("rst_mid_left", 32'(sample_left), 32'h0);
        check("rst_mid_right", 32'(sample_right), 32'h0);
        check("rst_mid_valid", 32'(sample_valid), 32'h0);
        check("rst_mid_err", 32'(frame_err), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        v0 = valid_cnt;
        send_bits(1'b1, 16'hFFFF, 7, 0);
        send_bits(1'b0, 16'hEEEE, 15, 0);
        check("rst_no_stale_valid", 32'(valid_cnt), 32'(v0));
        send_frame(16'h0246, 16'h8ACE);
        check("rst_post_cnt", 32'(valid_cnt), 32'(v0 + 1));
        check("rst_post_left", 32'(last_l), 32'h0246);
        check("rst_post_right", 32'(last_r), 32'h8ACE);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
